// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write strobes and the 2-bit ALUOp for ALUControl.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       FunctMask,
    output logic [2:0] ImmSrc,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StJal      = 4'd9,
        StBranch   = 4'd10,
        StLui      = 4'd11,
        StIllegal  = 4'd12
    } state_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;

    // Registered Moore part; the in_* flags enable the few live-input terms.
    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       illegal;
        logic       in_fetch;
        logic       in_branch;
        logic       in_execi;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.in_fetch  = 1'b1;
            end
            StDecode: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            StMemAdr: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            StMemRead: c.adrsrc = 1'b1;
            StMemWb: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            StMemWrite: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            StExecR: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b10;
            end
            StAluWb: c.regwrite = 1'b1;
            StExecI: begin
                c.alusrca  = 2'b10;
                c.alusrcb  = 2'b01;
                c.aluop    = 2'b10;
                c.in_execi = 1'b1;
            end
            StJal: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b10;
                c.pcwrite = 1'b1;
            end
            StBranch: begin
                c.alusrca   = 2'b10;
                c.aluop     = 2'b01;
                c.in_branch = 1'b1;
            end
            StLui: begin
                c.alusrca = 2'b11;
                c.alusrcb = 2'b01;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (MemReady) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = StBranch;
                    OpLui:           state_d = StLui;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  if (MemReady) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (MemReady) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StExecI:    state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StBranch:   state_d = StFetch;
            StLui:      state_d = StAluWb;
            default:    state_d = StIllegal;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            ctrl_q  <= decode_ctrl(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d);
        end
    end

    always_comb begin
        case (op)
            OpStore:  ImmSrc = 3'b001;
            OpBranch: ImmSrc = 3'b010;
            OpJal:    ImmSrc = 3'b011;
            OpLui:    ImmSrc = 3'b100;
            default:  ImmSrc = 3'b000;
        endcase
    end

    // Strobes are killed while reset is high so an abandoned instruction writes nothing.
    assign PCWrite   = ~reset & (ctrl_q.pcwrite | (ctrl_q.in_fetch & MemReady)
                                | (ctrl_q.in_branch & (Zero ^ funct3[0])));
    assign IRWrite   = ~reset & ctrl_q.in_fetch & MemReady;
    assign MemWrite  = ~reset & ctrl_q.memwrite;
    assign RegWrite  = ~reset & ctrl_q.regwrite;
    assign AdrSrc    = ctrl_q.adrsrc;
    assign ResultSrc = ctrl_q.resultsrc;
    assign ALUSrcA   = ctrl_q.alusrca;
    assign ALUSrcB   = ctrl_q.alusrcb;
    assign ALUOp     = ctrl_q.aluop;
    // SRAI is the only immediate op that must keep imm[11:5] as funct7.
    assign FunctMask = ctrl_q.in_execi & (funct3 != 3'b101);
    assign Illegal   = ctrl_q.illegal;
    assign State     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed sequences, an ImmSrc vector table and
// randomized instruction streams checked against an instruction-level reference model.
module tb_multicycle_control_fsm;

    logic       clk, reset, Zero, MemReady;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, FunctMask, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] State;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .FunctMask(FunctMask), .ImmSrc(ImmSrc), .Illegal(Illegal), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, aop;
        logic       fm;
        logic [2:0] imm;
        logic       ill;
    } obs_t;

    obs_t act;
    assign act = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUOp, FunctMask, ImmSrc, Illegal};

    typedef struct {
        logic [6:0] op;
        logic [2:0] imm;
    } imm_vec_t;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 3'b001;
        if (o == 7'b1100011) return 3'b010;
        if (o == 7'b1101111) return 3'b011;
        if (o == 7'b0110111) return 3'b100;
        return 3'b000;
    endfunction

    // Output table per state, straight from the state descriptions, plus the live-input terms.
    function automatic obs_t exp_obs(input int st, input logic r, input logic mr, input logic z,
                                     input logic [2:0] f3, input logic [6:0] o);
        obs_t e;
        e = '0;
        e.st  = st[3:0];
        e.imm = imm_of(o);
        case (st)
            0:  begin e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
            1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            3:  e.adr = 1'b1;
            4:  begin e.rs = 2'b01; e.rw = 1'b1; end
            5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            6:  begin e.sa = 2'b10; e.aop = 2'b10; end
            7:  e.rw = 1'b1;
            8:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; e.fm = (f3 != 3'b101); end
            9:  begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            10: begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = z ^ f3[0]; end
            11: begin e.sa = 2'b11; e.sb = 2'b01; end
            default: e.ill = 1'b1;
        endcase
        if (r) begin
            e.pcw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.mw = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, a, e);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, compare at the falling edge.
    task automatic cyc(input logic r, input logic mr, input logic z, input int st,
                       input string nm);
        reset = r; MemReady = mr; Zero = z;
        @(negedge clk);
        check(nm, 32'(act), 32'(exp_obs(st, r, mr, z, funct3, op)));
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: the state walk each instruction class takes.
    task automatic phases_of(input int k, output int ph[$]);
        case (k)
            0: ph = '{0, 1, 2, 3, 4};
            1: ph = '{0, 1, 2, 5};
            2: ph = '{0, 1, 6, 7};
            3: ph = '{0, 1, 8, 7};
            4: ph = '{0, 1, 9, 7};
            5: ph = '{0, 1, 10};
            default: ph = '{0, 1, 11, 7};
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        imm_vec_t imm_tab[8];
        logic [6:0] ops[7];
        imm_tab = '{'{7'b0100011, 3'b001}, '{7'b1100011, 3'b010}, '{7'b1101111, 3'b011},
                    '{7'b0110111, 3'b100}, '{7'b0000011, 3'b000}, '{7'b0010011, 3'b000},
                    '{7'b0110011, 3'b000}, '{7'b1100111, 3'b000}};
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011,
                7'b0110111};

        reset = 1'b1; MemReady = 1'b1; Zero = 1'b0; op = 7'b0110011; funct3 = 3'b000;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, "reset");

        op = 7'b0110011; funct3 = 3'b000;
        foreach (ops[i]) begin end
        cyc(0, 1, 0, 0, "add_fetch"); cyc(0, 1, 0, 1, "add_decode");
        cyc(0, 1, 0, 6, "add_exec");  cyc(0, 1, 0, 7, "add_wb");

        op = 7'b0000011; funct3 = 3'b010;
        cyc(0, 1, 0, 0, "lw_fetch"); cyc(0, 1, 0, 1, "lw_decode"); cyc(0, 1, 0, 2, "lw_adr");
        cyc(0, 0, 0, 3, "lw_stall1"); cyc(0, 0, 0, 3, "lw_stall2"); cyc(0, 1, 0, 3, "lw_read");
        cyc(0, 1, 0, 4, "lw_wb");

        op = 7'b1100011; funct3 = 3'b000;
        cyc(0, 1, 1, 0, "beq_fetch"); cyc(0, 1, 1, 1, "beq_decode");
        Zero = 1'b1;
        @(negedge clk);
        check("beq_taken_pcwrite", 32'(PCWrite), 32'd1);
        check("beq_aluop", 32'(ALUOp), 32'd1);
        @(posedge clk);
        #1;
        funct3 = 3'b001;
        cyc(0, 1, 1, 0, "bne_fetch"); cyc(0, 1, 1, 1, "bne_decode");
        @(negedge clk);
        check("bne_zero_pcwrite", 32'(PCWrite), 32'd0);
        check("bne_aluop", 32'(ALUOp), 32'd1);
        @(posedge clk);
        #1;

        op = 7'b0010011; funct3 = 3'b000;
        cyc(0, 1, 0, 0, "addi_fetch"); cyc(0, 1, 0, 1, "addi_decode");
        cyc(0, 1, 0, 8, "addi_exec"); cyc(0, 1, 0, 7, "addi_wb");
        funct3 = 3'b101;
        cyc(0, 1, 0, 0, "srai_fetch"); cyc(0, 1, 0, 1, "srai_decode");
        cyc(0, 1, 0, 8, "srai_exec"); cyc(0, 1, 0, 7, "srai_wb");

        op = 7'b0100011; funct3 = 3'b010;
        cyc(0, 1, 0, 0, "sw_fetch"); cyc(0, 1, 0, 1, "sw_decode"); cyc(0, 1, 0, 2, "sw_adr");
        cyc(0, 0, 0, 5, "sw_stall"); cyc(1, 0, 0, 5, "sw_reset");

        op = 7'b1111111; funct3 = 3'b000;
        cyc(0, 1, 0, 0, "ill_fetch"); cyc(0, 1, 0, 1, "ill_decode");
        for (int i = 0; i < 10; i++) cyc(0, i[0], i[1], 12, "ill_hold");
        cyc(1, 1, 0, 12, "ill_reset");

        // ImmSrc vectors, applied while FETCH stalls.
        reset = 1'b0; MemReady = 1'b0;
        foreach (imm_tab[i]) begin
            op = imm_tab[i].op;
            #1;
            check("immsrc", 32'(ImmSrc), 32'(imm_tab[i].imm));
        end
        @(posedge clk);
        #1;
        check("stall_state", 32'(State), 32'd0);

        for (int n = 0; n < 300; n++) begin
            int k;
            int ph[$];
            k = $urandom_range(0, 6);
            op = ops[k];
            funct3 = 3'($urandom);
            phases_of(k, ph);
            foreach (ph[i]) begin
                int   guard;
                logic mr, done;
                guard = 0;
                done  = 1'b0;
                while (!done) begin
                    mr = (guard > 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    cyc(0, mr, 1'($urandom), ph[i], "random");
                    guard++;
                    done = !((ph[i] == 0 || ph[i] == 3 || ph[i] == 5) && !mr);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
